// File: rtl/forward_pipe_pkg.sv
// ----------------------------------------------------------------------------
// forward_pipe_pkg
//
// Purpose : Shared elaboration helpers for the forward (valid/data) pipeline
//           slice and its backward skid buffer counterpart. Holds the
//           occupancy-counter width function and the L/DEPTH legality check
//           so both wrappers size and validate their parameters identically.
//
// Contents:
//   fp_count_width(depth)     -> bits needed to hold 0..depth
//   fp_params_legal(l, depth) -> 1 when both data width and depth are >= 1
// ----------------------------------------------------------------------------
package forward_pipe_pkg;

  // Smallest width able to represent every occupancy value 0..depth.
  function automatic int fp_count_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

  // A slice needs at least one data bit and at least one register stage.
  function automatic bit fp_params_legal(input int l, input int depth);
    return (l >= 32'sd1) && (depth >= 32'sd1);
  endfunction

endpackage : forward_pipe_pkg

// File: rtl/forward_pipe_stage.sv
// ----------------------------------------------------------------------------
// forward_pipe_stage
//
// Purpose : One forward-registered valid/data stage. The stage accepts a new
//           word whenever it is empty or its own word is leaving, which lets
//           an empty stage fill while the stage ahead is stalled (bubble
//           collapse). The ready path through the stage is combinational.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-low reset
//   in_valid   in   1  upstream word valid
//   in_data    in   L  upstream word
//   in_ready   out  1  stage can take the upstream word this cycle
//   out_valid  out  1  stage holds a word (registered)
//   out_data   out  L  held word (registered)
//   out_ready  in   1  downstream takes the held word this cycle
// ----------------------------------------------------------------------------
module forward_pipe_stage
  import forward_pipe_pkg::*;
#(
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [L-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [L-1:0] out_data,
  input  logic         out_ready
);

  logic         r_valid;
  logic [L-1:0] r_data;

  // The slot is free when empty, or when its current word leaves this edge.
  assign in_ready  = (!r_valid) || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Occupancy flag: loads the upstream valid whenever the slot is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Data register: only captures real words so idle cycles do not toggle it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= {L{1'b0}};
    end else if (in_ready && in_valid) begin
      r_data <= in_data;
    end else begin
      r_data <= r_data;
    end
  end

endmodule : forward_pipe_stage

// File: rtl/forward_pipe.sv
// ----------------------------------------------------------------------------
// forward_pipe
//
// Purpose : Forward-registered pipeline slice for a valid/ready stream. The
//           valid/data path is registered through DEPTH stages; the ready
//           path is a combinational chain back through the stages so that
//           empty stages keep accepting while the consumer stalls. Words leave
//           in acceptance order with no loss or duplication. A registered
//           occupancy count tracks the number of words held.
//
// Parameters:
//   L      data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1)
//   CW     occupancy count width, derived from DEPTH
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   asynchronous active-low reset
//   valid_f  in   1   upstream word valid
//   data_f   in   L   upstream word
//   ready_f  out  1   slice accepts the upstream word this cycle
//   valid_b  out  1   downstream word valid (registered)
//   data_b   out  L   downstream word (registered)
//   ready_b  in   1   downstream accepts the word this cycle
//   count    out  CW  number of words held (registered)
// ----------------------------------------------------------------------------
module forward_pipe
  import forward_pipe_pkg::*;
#(
  parameter int L     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = fp_count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_f,
  input  logic [L-1:0]  data_f,
  output logic          ready_f,
  output logic          valid_b,
  output logic [L-1:0]  data_b,
  input  logic          ready_b,
  output logic [CW-1:0] count
);

  if (!fp_params_legal(L, DEPTH)) begin : g_illegal_params
    $error("forward_pipe: L and DEPTH must both be at least 1");
  end

  // Index k of these chains is the input side of stage k; index DEPTH is the
  // consumer side of the last stage.
  logic [DEPTH:0] w_valid;
  logic [DEPTH:0] w_ready;
  logic [L-1:0]   w_data [0:DEPTH];

  logic           w_in_xfer;
  logic           w_out_xfer;
  logic [CW-1:0]  r_count;

  assign w_valid[0]     = valid_f;
  assign w_data[0]      = data_f;
  assign w_ready[DEPTH] = ready_b;

  assign ready_f = w_ready[0];
  assign valid_b = w_valid[DEPTH];
  assign data_b  = w_data[DEPTH];
  assign count   = r_count;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    forward_pipe_stage #(
      .L (L)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_valid[gi]),
      .in_data   (w_data[gi]),
      .in_ready  (w_ready[gi]),
      .out_valid (w_valid[gi+1]),
      .out_data  (w_data[gi+1]),
      .out_ready (w_ready[gi+1])
    );
  end

  // Words only enter at stage 0 and leave at the last stage; moves between
  // stages never change the total, so the count tracks the end handshakes.
  assign w_in_xfer  = valid_f && w_ready[0];
  assign w_out_xfer = w_valid[DEPTH] && ready_b;

  // Occupancy counter: push-only increments, pop-only decrements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {CW{1'b0}};
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1'b1);
        2'b01:   r_count <= r_count - CW'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : forward_pipe
